// File: rtl/upc_pkg.sv
// Shared types and constants for the checkout controller: FSM states and
// active-low seven-segment digit patterns (bit order g,f,e,d,c,b,a).
package upc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ALARM = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b100_0000;
    localparam logic [6:0] SEG_1     = 7'b111_1001;
    localparam logic [6:0] SEG_2     = 7'b010_0100;
    localparam logic [6:0] SEG_3     = 7'b011_0000;
    localparam logic [6:0] SEG_4     = 7'b001_1001;
    localparam logic [6:0] SEG_5     = 7'b001_0010;
    localparam logic [6:0] SEG_6     = 7'b000_0010;
    localparam logic [6:0] SEG_7     = 7'b111_1000;
    localparam logic [6:0] SEG_8     = 7'b000_0000;
    localparam logic [6:0] SEG_9     = 7'b001_0000;
    localparam logic [6:0] SEG_A     = 7'b000_1000;
    localparam logic [6:0] SEG_B     = 7'b000_0011;
    localparam logic [6:0] SEG_C     = 7'b100_0110;
    localparam logic [6:0] SEG_D     = 7'b010_0001;
    localparam logic [6:0] SEG_E     = 7'b000_0110;
    localparam logic [6:0] SEG_F     = 7'b000_1110;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

endpackage

// File: rtl/seg7_hex.sv
// Hex nibble to active-low seven-segment decoder (segment order g,f,e,d,c,b,a).
module seg7_hex
    import upc_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/upc_checkout_ctrl.sv
// Checkout controller: classifies scanned UPC codes, counts items/discounts per sale,
// latches a theft alarm until acknowledged. Optional blinking alarm via ALARM_BLINK_EN.
module upc_checkout_ctrl
    import upc_pkg::*;
#(
    parameter int                    UPC_W     = 3,
    parameter int                    CNT_W     = 8,
    parameter logic [2**UPC_W-1:0]   DISC_MASK = 8'b0011_0001,
    parameter logic [2**UPC_W-1:0]   EXP_MASK  = 8'b1100_0000,
    parameter int                    BLINK_DIV = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_valid,
    input  logic [UPC_W-1:0] upc,
    input  logic             marked,
    input  logic             close_sale,
    input  logic             alarm_ack,
    output logic             ready,
    output logic [CNT_W-1:0] item_cnt,
    output logic [CNT_W-1:0] disc_cnt,
    output logic             discount,
    output logic             alarm,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] item_d, disc_d;
    logic             discount_d, alarm_d;
    logic             stolen, disc;

`ifdef ALARM_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV) + 1;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign stolen = EXP_MASK[upc] & ~marked;
    assign disc   = DISC_MASK[upc];
    assign ready  = (state_q != ALARM);

    // A stolen scan always diverts to ALARM without touching the counts;
    // in SCAN that also drops a simultaneous close_sale.
    always_comb begin
        state_d    = state_q;
        item_d     = item_cnt;
        disc_d     = disc_cnt;
        discount_d = discount;
        case (state_q)
            IDLE, DONE: begin
                if (scan_valid) begin
                    if (stolen) begin
                        state_d = ALARM;
                    end else begin
                        item_d     = CNT_W'(1);
                        disc_d     = disc ? CNT_W'(1) : '0;
                        discount_d = disc;
                        state_d    = SCAN;
                    end
                end
            end
            SCAN: begin
                if (scan_valid && stolen) begin
                    state_d = ALARM;
                end else begin
                    if (scan_valid) begin
                        item_d     = sat_inc(item_cnt);
                        disc_d     = disc ? sat_inc(disc_cnt) : disc_cnt;
                        discount_d = disc;
                    end
                    if (close_sale)
                        state_d = DONE;
                end
            end
            ALARM: begin
                if (alarm_ack)
                    state_d = SCAN;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ALARM_BLINK_EN
    // Alarm starts high on entry, then toggles each time the divider wraps.
    always_comb begin
        alarm_d     = 1'b0;
        blink_cnt_d = '0;
        if (state_d == ALARM) begin
            if (state_q != ALARM) begin
                alarm_d = 1'b1;
            end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                alarm_d = ~alarm;
            end else begin
                alarm_d     = alarm;
                blink_cnt_d = blink_cnt + BLINK_W'(1);
            end
        end
    end
`else
    always_comb begin
        alarm_d = (state_d == ALARM);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            item_cnt <= '0;
            disc_cnt <= '0;
            discount <= 1'b0;
            alarm    <= 1'b0;
`ifdef ALARM_BLINK_EN
            blink_cnt <= '0;
`endif
        end else begin
            state_q  <= state_d;
            item_cnt <= item_d;
            disc_cnt <= disc_d;
            discount <= discount_d;
            alarm    <= alarm_d;
`ifdef ALARM_BLINK_EN
            blink_cnt <= blink_cnt_d;
`endif
        end
    end

    seg7_hex u_hex0 (
        .nibble (item_cnt[3:0]),
        .seg    (hex0)
    );

    seg7_hex u_hex1 (
        .nibble (item_cnt[7:4]),
        .seg    (hex1)
    );

endmodule
